program_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of `processor_top`. It receives framed bytes over a valid/ready handshake, assembles big-endian 32-bit words and drives the core's instruction-memory and data-memory write ports (`instr`/`instr_addr`/`ins_we`, `data`/`data_addr`/`data_we`). It holds the core in reset through `core_rst` until a verified GO command arrives. It replaces testbench-driven memory loading in system-level runs.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_if.sv | 9 +
 rtl/program_loader_word_assembler.sv | 44 ++++
 rtl/program_loader.sv | 170 +++++++++++++++++
 tb/tb_program_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and state type for the byte-stream program loader.
package loader_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [7:0] CMD_INSTR = 8'h49;
  localparam logic [7:0] CMD_DATA  = 8'h44;
  localparam logic [7:0] CMD_GO    = 8'h47;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_COUNT,
    ST_PAYLOAD,
    ST_CHK,
    ST_RUN
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream valid/ready link feeding the loader.
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs four stream bytes, MSB first, into a 32-bit word.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  // The completed word includes the byte arriving this cycle, so the caller
  // can register it on the same edge that accepts the 4th byte.
  assign word       = {shift_q[23:0], byte_in};
  assign word_valid = byte_valid && !frame_start && (idx_q == 2'd3);

  // Next shift-register and byte-index values.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (frame_start) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[23:0], byte_in};
      idx_d   = idx_q + 2'd1;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Frame-parsing loader: writes instruction/data memories, then releases the core.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   rx,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              ins_we,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_we,
  output logic              core_rst,
  output logic              load_done,
  output logic              err
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic              tgt_data_q, tgt_data_d;
  logic              err_q, err_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;
  logic [DATA_W-1:0] instr_q, instr_d, data_q, data_d;
  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d, data_addr_q, data_addr_d;
  logic              ins_we_q, ins_we_d, data_we_q, data_we_d;

  logic        accept;
  logic [31:0] asm_word;
  logic        asm_valid;

  assign rx.rx_ready = (state_q != ST_RUN);
  assign accept      = rx.rx_valid && rx.rx_ready;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .frame_start(accept && (state_q == ST_IDLE)),
    .byte_valid (accept && (state_q == ST_PAYLOAD)),
    .byte_in    (rx.rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Frame parser: next state, counters, checksum and write-port values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    tgt_data_d   = tgt_data_q;
    err_d        = err_q;
    core_rst_d   = core_rst_q;
    load_done_d  = load_done_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    data_d       = data_q;
    data_addr_d  = data_addr_q;
    ins_we_d     = 1'b0;
    data_we_d    = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (rx.rx_data == CMD_INSTR || rx.rx_data == CMD_DATA) begin
            tgt_data_d = (rx.rx_data == CMD_DATA);
            xor_d      = rx.rx_data;
            state_d    = ST_ADDR_HI;
          end else if (rx.rx_data == CMD_GO) begin
            if (!err_q) begin
              state_d     = ST_RUN;
              core_rst_d  = 1'b0;
              load_done_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        ST_ADDR_HI: begin
          addr_d  = ADDR_W'({rx.rx_data[1:0], 8'h00});
          xor_d   = xor_q ^ rx.rx_data;
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d  = addr_q | ADDR_W'(rx.rx_data);
          xor_d   = xor_q ^ rx.rx_data;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          cnt_d   = (rx.rx_data == 8'h00) ? 9'd256 : {1'b0, rx.rx_data};
          xor_d   = xor_q ^ rx.rx_data;
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          xor_d = xor_q ^ rx.rx_data;
          if (asm_valid) begin
            if (tgt_data_q) begin
              data_d      = DATA_W'(asm_word);
              data_addr_d = addr_q;
              data_we_d   = 1'b1;
            end else begin
              instr_d      = DATA_W'(asm_word);
              instr_addr_d = addr_q;
              ins_we_d     = 1'b1;
            end
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - 9'd1;
            if (cnt_q == 9'd1) state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx.rx_data != xor_q) err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // All state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      xor_q        <= '0;
      tgt_data_q   <= 1'b0;
      err_q        <= 1'b0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      instr_q      <= '0;
      instr_addr_q <= '0;
      data_q       <= '0;
      data_addr_q  <= '0;
      ins_we_q     <= 1'b0;
      data_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      tgt_data_q   <= tgt_data_d;
      err_q        <= err_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      data_q       <= data_d;
      data_addr_q  <= data_addr_d;
      ins_we_q     <= ins_we_d;
      data_we_q    <= data_we_d;
    end
  end

  assign instr      = instr_q;
  assign instr_addr = instr_addr_q;
  assign ins_we     = ins_we_q;
  assign data       = data_q;
  assign data_addr  = data_addr_q;
  assign data_we    = data_we_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, corner sequences, random frames.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, data;
  logic [9:0]  instr_addr, data_addr;
  logic        ins_we, data_we, core_rst, load_done, err;

  always #5 clk = ~clk;

  program_loader_if rx ();

  program_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .instr     (instr),
    .instr_addr(instr_addr),
    .ins_we    (ins_we),
    .data      (data),
    .data_addr (data_addr),
    .data_we   (data_we),
    .core_rst  (core_rst),
    .load_done (load_done),
    .err       (err)
  );

  typedef struct {
    logic        is_d;
    logic [9:0]  a;
    logic [31:0] w;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd, hi, lo, cnt;
    logic [31:0] w0, w1;
    logic [7:0]  corrupt;
    logic        exp_d;
    logic [9:0]  exp_a0, exp_a1;
    int          exp_n;
    logic        exp_err;
  } vec_t;

  int          n_vec = 0;
  int          n_fail = 0;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] pay_q[$];
  vec_t        tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture every write strobe seen on the memory ports.
  always @(negedge clk) begin
    if (!rst) begin
      if (ins_we || data_we) check("we_exclusive", 64'(ins_we & data_we), 64'd0);
      if (ins_we)  got_q.push_back('{1'b0, instr_addr, instr});
      if (data_we) got_q.push_back('{1'b1, data_addr, data});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    @(posedge clk);
    #1 rx.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Sends a block frame built from pay_q; optionally records the model's expected writes.
  task automatic send_frame(input logic [7:0] cmd, hi, lo, cnt, corrupt,
                            input bit model, input bit gaps);
    logic [7:0] x;
    int         n, base;
    n    = (cnt == 8'h00) ? 256 : int'(cnt);
    base = int'(hi[1:0]) * 256 + int'(lo);
    x    = cmd ^ hi ^ lo ^ cnt;
    send_byte(cmd); send_byte(hi); send_byte(lo); send_byte(cnt);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = pay_q[i][k*8 +: 8];
        x = x ^ b;
        send_byte(b);
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
      end
      if (model) exp_q.push_back('{cmd == 8'h44, 10'((base + i) % 1024), pay_q[i]});
    end
    send_byte(x ^ corrupt);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_port"}, 64'(got_q[i].is_d), 64'(exp_q[i].is_d));
      check({tag, "_addr"}, 64'(got_q[i].a), 64'(exp_q[i].a));
      check({tag, "_word"}, 64'(got_q[i].w), 64'(exp_q[i].w));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_rx_ready"}, 64'(rx.rx_ready), 64'd1);
    check({tag, "_flags"}, 64'({load_done, err, ins_we, data_we}), 64'd0);
    check({tag, "_words"}, {instr, data}, 64'd0);
    check({tag, "_addrs"}, 64'({instr_addr, data_addr}), 64'd0);
  endtask

  initial begin
    logic [7:0] x;
    logic       err_m;

    rx.rx_data  = 8'h00;
    rx.rx_valid = 1'b0;
    rst         = 1'b1;

    //        cmd    hi     lo     cnt    w0            w1            corrupt d     a0      a1      n  err
    tbl[0] = '{8'h49, 8'h00, 8'h00, 8'h01, 32'h012A4020, 32'h00000000, 8'h00, 1'b0, 10'h000, 10'h000, 1, 1'b0};
    tbl[1] = '{8'h44, 8'h03, 8'hFF, 8'h02, 32'h00000005, 32'h00000007, 8'h00, 1'b1, 10'h3FF, 10'h000, 2, 1'b0};
    tbl[2] = '{8'h44, 8'hFC, 8'h10, 8'h01, 32'hDEADBEEF, 32'h00000000, 8'h00, 1'b1, 10'h010, 10'h000, 1, 1'b0};
    tbl[3] = '{8'h49, 8'h02, 8'h05, 8'h02, 32'h11223344, 32'h55667788, 8'h01, 1'b0, 10'h205, 10'h206, 2, 1'b1};
    tbl[4] = '{8'h49, 8'hFE, 8'h80, 8'h02, 32'hA5A5A5A5, 32'h0000FFFF, 8'h00, 1'b0, 10'h280, 10'h281, 2, 1'b0};

    do_reset();
    check_reset_outputs("reset");

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      pay_q.delete();
      pay_q.push_back(tbl[v].w0);
      if (tbl[v].exp_n == 2) pay_q.push_back(tbl[v].w1);
      send_frame(tbl[v].cmd, tbl[v].hi, tbl[v].lo, tbl[v].cnt, tbl[v].corrupt, 1'b0, 1'b0);
      idle(3);
      exp_q.push_back('{tbl[v].exp_d, tbl[v].exp_a0, tbl[v].w0});
      if (tbl[v].exp_n == 2) exp_q.push_back('{tbl[v].exp_d, tbl[v].exp_a1, tbl[v].w1});
      compare_writes($sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_err", v), 64'(err), 64'(tbl[v].exp_err));
    end

    // Reset after the 2nd payload byte, then a fresh frame with exact strobe timing.
    do_reset();
    send_byte(8'h49); send_byte(8'h00); send_byte(8'h07); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic [63:0] fr;
      logic [7:0]  b;
      fr = 64'h4900070111223344;
      b  = fr[(7-i)*8 +: 8];
      x  = x ^ b;
      send_byte(b);
    end
    @(negedge clk);
    check("lat_we_pulse", 64'({ins_we, data_we}), 64'b10);
    check("lat_word", 64'(instr), 64'h11223344);
    check("lat_addr", 64'(instr_addr), 64'h007);
    @(negedge clk);
    check("lat_we_drop", 64'({ins_we, data_we}), 64'b00);
    check("lat_hold", 64'({instr_addr, instr}), 64'({10'h007, 32'h11223344}));
    send_byte(x);
    idle(2);
    check("fresh_err", 64'(err), 64'd0);
    check("fresh_writes", 64'(got_q.size()), 64'd1);
    got_q.delete();

    // Unknown byte in IDLE, then a valid frame still writes, then GO is refused.
    do_reset();
    send_byte(8'h55);
    idle(1);
    check("bad_err", 64'(err), 64'd1);
    check("bad_ready", 64'(rx.rx_ready), 64'd1);
    pay_q.delete();
    pay_q.push_back(32'hCAFEF00D);
    send_frame(8'h44, 8'h01, 8'h23, 8'h01, 8'h00, 1'b1, 1'b0);
    idle(3);
    compare_writes("after_bad");
    send_byte(8'h47);
    @(negedge clk);
    check("go_blocked", 64'({core_rst, load_done, rx.rx_ready}), 64'b101);

    // Corrupted CHK: writes stand, err set, GO refused.
    do_reset();
    pay_q.delete();
    pay_q.push_back(32'h01020304);
    pay_q.push_back(32'h05060708);
    send_frame(8'h49, 8'h00, 8'h10, 8'h02, 8'h80, 1'b1, 1'b0);
    idle(2);
    compare_writes("badchk");
    send_byte(8'h47);
    @(negedge clk);
    check("badchk_go", 64'({err, core_rst, load_done}), 64'b110);

    // Valid frame then GO: core released and stream closed.
    do_reset();
    pay_q.delete();
    pay_q.push_back(32'h00000013);
    send_frame(8'h49, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
    idle(2);
    compare_writes("pre_go");
    check("pre_go_core_rst", 64'(core_rst), 64'd1);
    send_byte(8'h47);
    @(negedge clk);
    check("go_state", 64'({core_rst, load_done, rx.rx_ready}), 64'b010);
    for (int i = 0; i < 8; i++) send_byte(8'h49);
    idle(2);
    check("run_no_writes", 64'(got_q.size()), 64'd0);
    check("run_sticky", 64'({core_rst, load_done, rx.rx_ready, err}), 64'b0100);

    // COUNT=0 means 256 words, starting near the top so the address wraps.
    do_reset();
    pay_q.delete();
    for (int i = 0; i < 256; i++) pay_q.push_back($urandom);
    send_frame(8'h44, 8'h03, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0);
    idle(2);
    compare_writes("cnt256");
    check("cnt256_err", 64'(err), 64'd0);

    // Random frames checked against the frame-level model.
    do_reset();
    err_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h44 || b == 8'h47 || b == 8'h49) b = 8'h00;
        send_byte(b);
        err_m = 1'b1;
      end else begin
        logic [7:0] cmd, cnt, cor;
        cmd = ($urandom_range(0, 1) == 1) ? 8'h44 : 8'h49;
        cnt = 8'($urandom_range(1, 4));
        cor = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        if (cor != 8'h00) err_m = 1'b1;
        pay_q.delete();
        for (int i = 0; i < int'(cnt); i++) pay_q.push_back($urandom);
        send_frame(cmd, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), cnt, cor,
                   1'b1, 1'b1);
      end
      idle($urandom_range(2, 4));
      compare_writes("rand");
      check("rand_err", 64'(err), 64'(err_m));
    end
    send_byte(8'h47);
    @(negedge clk);
    check("rand_go", 64'({core_rst, load_done}), 64'({err_m, ~err_m}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
